// File: rtl/mc_control.sv
// Multicycle MIPS main controller.
//
// state  | meaning
// -------+---------------------------------------------
// FETCH  | read instruction, PC <= PC + 4
// DECODE | read registers, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded word to rt
// MEMWR  | write rt to data memory
// RTEXE  | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare for beq, select branch target
// IEXE   | addi/ori ALU operation
// IWB    | write immediate result to rt
// JUMP   | load jump target into PC
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [3:0] State,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXE  = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXE   = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctl;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;

    // Moore decode of the control word for a given state.
    function automatic ctl_t decode_ctl(state_t s, logic [2:0] alu_sel);
        ctl_t c;
        c        = '0;
        c.aluctl = ALU_ADD;
        case (s)
            FETCH:  begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:  c.iord = 1'b1;
            MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTEXE:  begin c.alusrca = 1'b1; c.aluctl = alu_sel; end
            ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BRANCH: begin
                c.alusrca = 1'b1;
                c.aluctl  = 3'b110;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            IEXE:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctl = alu_sel; end
            IWB:    c.regwrite = 1'b1;
            JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    state_t     state, state_nxt;
    ctl_t       ctl;
    logic [2:0] alu_q, alu_nxt;
    logic       lw_q, lw_nxt;
    logic       rt_ok;
    logic [2:0] rt_alu;

    // Funct decode for supported R-type operations.
    always_comb begin
        rt_ok  = 1'b1;
        rt_alu = ALU_ADD;
        case (Funct)
            6'b100000: rt_alu = 3'b010;
            6'b100010: rt_alu = 3'b110;
            6'b100100: rt_alu = 3'b000;
            6'b100101: rt_alu = 3'b001;
            6'b101010: rt_alu = 3'b111;
            default:   rt_ok  = 1'b0;
        endcase
    end

    // Next state; the opcode is captured in DECODE so later opcode changes are ignored.
    always_comb begin
        state_nxt = FETCH;
        alu_nxt   = alu_q;
        lw_nxt    = lw_q;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                lw_nxt = (Op == OP_LW);
                case (Op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE: if (rt_ok) begin
                        state_nxt = RTEXE;
                        alu_nxt   = rt_alu;
                    end
                    OP_BEQ:  state_nxt = BRANCH;
                    OP_ADDI: begin state_nxt = IEXE; alu_nxt = 3'b010; end
                    OP_ORI:  begin state_nxt = IEXE; alu_nxt = 3'b001; end
                    OP_J:    state_nxt = JUMP;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: state_nxt = lw_q ? MEMRD : MEMWR;
            MEMRD:  state_nxt = MEMWB;
            RTEXE:  state_nxt = ALUWB;
            IEXE:   state_nxt = IWB;
            default: state_nxt = FETCH;
        endcase
    end

    // State register with the control word registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ctl   <= decode_ctl(FETCH, ALU_ADD);
            alu_q <= ALU_ADD;
            lw_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            ctl   <= decode_ctl(state_nxt, alu_nxt);
            alu_q <= alu_nxt;
            lw_q  <= lw_nxt;
        end
    end

    // Write enables are held off while reset is high, independent of the clock.
    assign State      = state;
    assign PCEn       = ~reset & (ctl.pcwrite | (ctl.branch & Zero));
    assign IRWrite    = ~reset & ctl.irwrite;
    assign RegWrite   = ~reset & ctl.regwrite;
    assign MemWrite   = ~reset & ctl.memwrite;
    assign IorD       = ctl.iord;
    assign RegDst     = ctl.regdst;
    assign MemtoReg   = ctl.memtoreg;
    assign ALUSrcA    = ctl.alusrca;
    assign ALUSrcB    = ctl.alusrcb;
    assign PCSrc      = ctl.pcsrc;
    assign ALUControl = ctl.aluctl;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: table of instructions plus randomized instruction
// stream, each checked cycle by cycle against a path/output model.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic [3:0] State;
    logic       PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;

    int total  = 0;
    int passed = 0;

    logic [3:0] path_q[$];

    mc_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .State(State), .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         zforce;
        int         len;
        string      name;
    } vec_t;

    function automatic logic [14:0] get_out();
        return {PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, PCSrc, ALUControl};
    endfunction

    function automatic bit funct_ok(logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] funct_alu(logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Sequence of states visited by one instruction, starting at FETCH.
    task automatic set_path(input logic [5:0] op, input logic [5:0] funct);
        path_q = {4'd0, 4'd1};
        case (op)
            6'b100011: path_q = {path_q, 4'd2, 4'd3, 4'd4};
            6'b101011: path_q = {path_q, 4'd2, 4'd5};
            6'b000000: if (funct_ok(funct)) path_q = {path_q, 4'd6, 4'd7};
            6'b000100: path_q = {path_q, 4'd8};
            6'b001000, 6'b001101: path_q = {path_q, 4'd9, 4'd10};
            6'b000010: path_q = {path_q, 4'd11};
            default: ;
        endcase
    endtask

    function automatic logic [14:0] exp_out(logic [3:0] st, logic [5:0] op,
                                            logic [5:0] funct, logic z, logic rst);
        logic pcw = 0, br = 0, iord = 0, mw = 0, irw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        case (st)
            4'd0:  begin irw = 1; pcw = 1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  iord = 1;
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iord = 1; mw = 1; end
            4'd6:  begin sa = 1; alu = funct_alu(funct); end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; alu = 3'b110; ps = 2'b01; br = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; alu = (op == 6'b001101) ? 3'b001 : 3'b010; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (rst) begin pcw = 0; br = 0; irw = 0; rw = 0; mw = 0; end
        return {pcw | (br & z), iord, mw, irw, rw, rd, m2r, sa, sb, ps, alu};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs one instruction from FETCH until State returns to FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input int zforce, input int exp_len, input string name);
        int n;
        logic [3:0] st;
        set_path(op, funct);
        n = 0;
        do begin
            st = (n < path_q.size()) ? path_q[n] : 4'hf;
            if (st == 4'd1 || st == 4'd6 || st == 4'd9) begin
                Op = op; Funct = funct;
            end else begin
                Op = 6'($urandom); Funct = 6'($urandom);
            end
            Zero = 1'($urandom);
            if (st == 4'd8 && zforce >= 0) Zero = zforce[0];
            #1;
            chk({name, " state"}, 32'(State), 32'(st));
            chk({name, " outputs"}, 32'(get_out()), 32'(exp_out(st, op, funct, Zero, 1'b0)));
            @(posedge clk); #1;
            n++;
        end while (State !== 4'd0 && n < 10);
        chk({name, " cycles"}, n, (exp_len >= 0) ? exp_len : path_q.size());
    endtask

    task automatic step_hold(input logic [5:0] op, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            Op = op; Funct = 6'b0; Zero = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[$];
    logic [5:0] rops[8];
    logic [5:0] rfun[6];

    initial begin
        vecs = '{
            '{6'b100011, 6'b000000, -1, 5, "lw"},
            '{6'b101011, 6'b000000, -1, 4, "sw"},
            '{6'b000000, 6'b100000, -1, 4, "add"},
            '{6'b000000, 6'b100010, -1, 4, "sub"},
            '{6'b000000, 6'b100100, -1, 4, "and"},
            '{6'b000000, 6'b100101, -1, 4, "or"},
            '{6'b000000, 6'b101010, -1, 4, "slt"},
            '{6'b000000, 6'b000000, -1, 2, "rtype_bad"},
            '{6'b000100, 6'b000000,  1, 3, "beq_taken"},
            '{6'b000100, 6'b000000,  0, 3, "beq_not"},
            '{6'b001000, 6'b000000, -1, 4, "addi"},
            '{6'b001101, 6'b000000, -1, 4, "ori"},
            '{6'b000010, 6'b000000, -1, 3, "j"},
            '{6'b111111, 6'b000000, -1, 2, "op_bad"}
        };
        rops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                 6'b001000, 6'b001101, 6'b000010, 6'b110011};
        rfun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

        reset = 1'b1; Op = 6'b100011; Funct = 6'b0; Zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(State), 32'd0);
        chk("reset outputs", 32'(get_out()), 32'(exp_out(4'd0, Op, Funct, Zero, 1'b1)));
        reset = 1'b0;

        foreach (vecs[i])
            run_instr(vecs[i].op, vecs[i].funct, vecs[i].zforce, vecs[i].len, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] op, fn;
            op = rops[$urandom_range(7)];
            fn = rfun[$urandom_range(5)];
            if ($urandom_range(7) == 0) op = 6'($urandom);
            run_instr(op, fn, -1, -1, "random");
        end

        // sw aborted in MEMWR
        step_hold(6'b101011, 3);
        chk("sw reach memwr", 32'(State), 32'd5);
        chk("sw memwrite before reset", 32'(MemWrite), 32'd1);
        reset = 1'b1; #1;
        chk("sw reset outputs", 32'(get_out()), 32'(exp_out(4'd5, Op, Funct, Zero, 1'b1)));
        @(posedge clk); #1;
        chk("sw reset state", 32'(State), 32'd0);
        chk("sw reset held outputs", 32'(get_out()), 32'(exp_out(4'd0, Op, Funct, Zero, 1'b1)));
        reset = 1'b0; #1;
        chk("post reset fetch", 32'({IRWrite, PCEn}), 32'b11);
        run_instr(6'b000000, 6'b100101, -1, 4, "after_sw_reset");

        // lw aborted in MEMWB
        step_hold(6'b100011, 4);
        chk("lw reach memwb", 32'(State), 32'd4);
        reset = 1'b1; #1;
        chk("lw reset regwrite", 32'(RegWrite), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(6'b100011, 6'b000000, -1, 5, "after_lw_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
